mult_div_seq: RTL and testbench



---
 rtl/mips_pkg.sv | 27 ++
 rtl/mult_div_seq.sv | 189 ++++++++++++++++++
 tb/tb_mult_div_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core.
//
// Holds the MULT/DIV function-field codes, the op select encoding used by
// the MultOrDiv control line, the mult/div sequencer state type and the
// default datapath width. ctrl_unit decodes FUNCT against the same
// constants, so both sides agree on the encoding.
package mips_pkg;

   // FUNCT field codes for R-type MULT and DIV
   localparam logic [5:0] MULT = 6'b011000;
   localparam logic [5:0] DIV  = 6'b011010;

   // op / MultOrDiv encoding
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_FIX  = 3'd3,
      DONE     = 3'd4
   } md_state_t;

endpackage

// File: rtl/mult_div_seq.sv
// Multi-cycle MULT/DIV sequencer for the multicycle MIPS core.
//
// Captures rs/rt on a start pulse accepted in IDLE and runs either radix-2
// Booth multiplication (WIDTH steps) or restoring division on magnitudes
// (WIDTH steps plus one sign-correction step). The 2*WIDTH result lands in
// hi/lo on the edge entering DONE, where done pulses for one cycle.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; clears all state and outputs
//   start     begin an operation; only sampled in IDLE
//   op        0 = MULT, 1 = DIV
//   a         rs operand (multiplicand / dividend), signed
//   b         rt operand (multiplier / divisor), signed
//   busy      high in every state except IDLE
//   done      one-cycle pulse, hi/lo valid
//   div_zero  DIV with b == 0; held until the next accepted start
//   hi        MULT: product high word; DIV: remainder
//   lo        MULT: product low word;  DIV: quotient
module mult_div_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // One extra bit so the counter can never wrap inside an operation
   localparam int CNT_W = $clog2(WIDTH) + 1;

   md_state_t        r_state;
   md_state_t        w_next_state;

   logic [CNT_W-1:0] r_cnt;
   // r_acc: Booth P_hi (with guard bit) in MULT, partial remainder in DIV
   logic [WIDTH:0]   r_acc;
   // r_shf: Booth P_lo in MULT, dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] r_shf;
   logic             r_qm1;
   // r_mcand: multiplicand in MULT, |divisor| in DIV
   logic [WIDTH-1:0] r_mcand;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_last;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_mext;
   logic [WIDTH:0]   w_booth_sum;
   logic [WIDTH:0]   w_rs;
   logic [WIDTH+1:0] w_diff;
   logic             w_div_neg;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_a_mag = a[WIDTH-1] ? -a : a;
   assign w_b_mag = b[WIDTH-1] ? -b : b;

   // Booth step: the guard bit keeps -MIN_INT representable in P_hi
   assign w_mext = {r_mcand[WIDTH-1], r_mcand};
   always_comb begin
      w_booth_sum = r_acc;
      case ({r_shf[0], r_qm1})
         2'b01:   w_booth_sum = r_acc + w_mext;
         2'b10:   w_booth_sum = r_acc - w_mext;
         default: w_booth_sum = r_acc;
      endcase
   end

   // Restoring step: shift next dividend bit in, trial-subtract |b|;
   // the extra top bit of w_diff is the borrow that signals "restore"
   assign w_rs      = {r_acc[WIDTH-1:0], r_shf[WIDTH-1]};
   assign w_diff    = {1'b0, w_rs} - {2'b00, r_mcand};
   assign w_div_neg = w_diff[WIDTH+1];

   // Sign correction; MIN_INT / -1 wraps back to MIN_INT with no flag
   assign w_q_fix = r_neg_q ? -r_shf : r_shf;
   assign w_r_fix = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (op == OP_MULT)  w_next_state = MULT_RUN;
               else if (b == '0)   w_next_state = DONE;
               else                w_next_state = DIV_RUN;
            end
         end
         MULT_RUN: if (w_last) w_next_state = DONE;
         DIV_RUN:  if (w_last) w_next_state = DIV_FIX;
         DIV_FIX:  w_next_state = DONE;
         DONE:     w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      busy     = (r_state != IDLE);
      done     = (r_state == DONE);
      div_zero = r_div_zero;
      hi       = r_hi;
      lo       = r_lo;
   end

   // Datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_shf      <= '0;
         r_qm1      <= 1'b0;
         r_mcand    <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt      <= '0;
                  r_acc      <= '0;
                  r_qm1      <= 1'b0;
                  r_div_zero <= (op == OP_DIV) && (b == '0);
                  if (op == OP_MULT) begin
                     r_shf   <= b;
                     r_mcand <= a;
                  end else begin
                     r_shf   <= w_a_mag;
                     r_mcand <= w_b_mag;
                     r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                     r_neg_r <= a[WIDTH-1];
                  end
               end
            end
            MULT_RUN: begin
               r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
               r_shf <= {w_booth_sum[0], r_shf[WIDTH-1:1]};
               r_qm1 <= r_shf[0];
               r_cnt <= r_cnt + 1'b1;
               // Final step writes the shifted product straight to hi/lo
               if (w_last) begin
                  r_hi <= w_booth_sum[WIDTH:1];
                  r_lo <= {w_booth_sum[0], r_shf[WIDTH-1:1]};
               end
            end
            DIV_RUN: begin
               r_acc <= w_div_neg ? w_rs : w_diff[WIDTH:0];
               r_shf <= {r_shf[WIDTH-2:0], ~w_div_neg};
               r_cnt <= r_cnt + 1'b1;
            end
            DIV_FIX: begin
               r_hi <= w_r_fix;
               r_lo <= w_q_fix;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq.
module tb_mult_div_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;

   mult_div_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Issue one operation, scramble the inputs after the start edge, and
   // count negedges until done is seen. cyc_o is the edge number at which
   // done is sampled, counting the start-sampling edge as 0 (100 = timeout).
   task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input int repulse_at, output int cyc_o);
      @(negedge clk);
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = ~op_i;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0;
      chk("busy_after_start", {63'b0, busy}, 64'd1);
      cyc_o = 100;
      for (int i = 1; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            cyc_o = i;
            break;
         end
         if (i == repulse_at) begin
            start = 1'b1;
            op    = 1'b0;
            a     = 32'd1;
            b     = 32'd1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   // One cycle after done: pulse has ended and the sequencer is idle
   task automatic chk_after_done(input string tag);
      @(negedge clk);
      chk({tag, "_done_low"}, {63'b0, done}, 64'd0);
      chk({tag, "_busy_low"}, {63'b0, busy}, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_divz", {63'b0, div_zero}, 64'd0);
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // 7 * -3 = -21
      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, cyc);
      chk("m1_lat", cyc, 64'd33);
      chk("m1_hi", {32'b0, hi}, 64'hFFFF_FFFF);
      chk("m1_lo", {32'b0, lo}, 64'hFFFF_FFEB);
      chk("m1_divz", {63'b0, div_zero}, 64'd0);
      chk_after_done("m1");

      // MIN_INT * MIN_INT = 2^62
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, cyc);
      chk("m2_hi", {32'b0, hi}, 64'h4000_0000);
      chk("m2_lo", {32'b0, lo}, 64'h0000_0000);

      // -7 / 2 = -3 rem -1
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, cyc);
      chk("d1_lat", cyc, 64'd34);
      chk("d1_lo", {32'b0, lo}, 64'hFFFF_FFFD);
      chk("d1_hi", {32'b0, hi}, 64'hFFFF_FFFF);
      chk_after_done("d1");

      // 6 * 0x2AAAAAAB = 0x1_00000002 leaves hi=1, lo=2
      run_op(1'b0, 32'd6, 32'h2AAA_AAAB, 0, cyc);
      chk("m3_hi", {32'b0, hi}, 64'h1);
      chk("m3_lo", {32'b0, lo}, 64'h2);

      // 5 / 0: immediate done, flag set, hi/lo untouched
      run_op(1'b1, 32'd5, 32'd0, 0, cyc);
      chk("dz_lat", cyc, 64'd1);
      chk("dz_flag", {63'b0, div_zero}, 64'd1);
      chk("dz_hi", {32'b0, hi}, 64'h1);
      chk("dz_lo", {32'b0, lo}, 64'h2);
      chk_after_done("dz");
      @(negedge clk);
      chk("dz_flag_held", {63'b0, div_zero}, 64'd1);

      // 100 / 7 with an ignored start re-pulse mid-run
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 32'd100;
      b     = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("dz_flag_cleared", {63'b0, div_zero}, 64'd0);
      cyc = 100;
      for (int i = 1; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            cyc = i;
            break;
         end
         start = (i == 10);
         op    = (i == 10) ? 1'b0 : 1'b1;
         a     = (i == 10) ? 32'd1 : 32'd100;
         b     = (i == 10) ? 32'd1 : 32'd7;
      end
      start = 1'b0;
      chk("d2_lat", cyc, 64'd34);
      chk("d2_lo", {32'b0, lo}, 64'd14);
      chk("d2_hi", {32'b0, hi}, 64'd2);
      chk_after_done("d2");

      // MIN_INT / -1 wraps without a flag
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc);
      chk("d3_lo", {32'b0, lo}, 64'h8000_0000);
      chk("d3_hi", {32'b0, hi}, 64'h0);
      chk("d3_divz", {63'b0, div_zero}, 64'd0);

      // 7 / -2 = -3 rem 1 (remainder follows the dividend's sign)
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, cyc);
      chk("d4_lo", {32'b0, lo}, 64'hFFFF_FFFD);
      chk("d4_hi", {32'b0, hi}, 64'h1);

      // Reset in the middle of a MULT acts without a clock edge
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      a     = 32'd5;
      b     = 32'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 10; i++) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("ar_busy", {63'b0, busy}, 64'd0);
      chk("ar_done", {63'b0, done}, 64'd0);
      chk("ar_hi", {32'b0, hi}, 64'd0);
      chk("ar_lo", {32'b0, lo}, 64'd0);
      #2;
      reset = 1'b0;

      run_op(1'b0, 32'd3, 32'd4, 0, cyc);
      chk("m4_lat", cyc, 64'd33);
      chk("m4_lo", {32'b0, lo}, 64'd12);
      chk("m4_hi", {32'b0, hi}, 64'd0);
      chk_after_done("m4");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
